aes_job_sched: RTL and testbench
================================

Name: aes_job_sched

Overview:
- Round-robin scheduler that shares one AES core between NREQ requesters.
- Per job: grants one requester, drives key and plaintext to the core, pulses start, waits for output-valid, then returns the ciphertext tagged with the requester ID.
- A watchdog bounds core latency. On timeout it aborts the job with an error response and a core clear, so a stalled or tampered core cannot hang the system.
- Sits between the requester fabric and the aes_core register interface.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal clog2(NREQ).
- TIMEOUT_CYC, 64, maximum cycles allowed in WAIT before abort.
- CLR_CYC, 4, cycles aes_clear_o is held after an abort.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  NREQ  per-requester job request
- req_ready_o  out  NREQ  per-requester accept; at most one bit high
- req_key_i  in  NREQ*128  per-requester AES-128 key (slice i)
- req_data_i  in  NREQ*128  per-requester plaintext (slice i)
- aes_key_o  out  128  key to core
- aes_data_o  out  128  plaintext to core
- aes_start_o  out  1  one-cycle start pulse
- aes_clear_o  out  1  core clear/flush
- aes_idle_i  in  1  core idle
- aes_out_valid_i  in  1  core output valid
- aes_out_i  in  128  core ciphertext
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accept
- rsp_id_o  out  IDW  requester ID of response
- rsp_data_o  out  128  ciphertext; zero on error
- rsp_err_o  out  1  1 = timeout abort
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_i=1 at posedge, dominates all else):
  - State=IDLE, RR pointer=0, watchdog=0.
  - All outputs 0, including key/data/rsp registers.
  - A job in flight is dropped with no response. aes_clear_o is not asserted by reset.
- Valid/ready rule: transfer occurs when valid&ready are both high at a posedge.
- State machine:
  - IDLE: if any req_valid_i and aes_idle_i, select the first set bit at or after RR pointer (wrapping). Assert req_ready_o[sel] combinationally the same cycle. On that edge capture the key, data and ID into registers. Go LOAD. If aes_idle_i=0, no grant.
  - LOAD: registered key/data drive aes_key_o/aes_data_o (held stable until the next grant). Go START.
  - START: aes_start_o=1 for exactly this cycle; watchdog cleared. Go WAIT.
  - WAIT: watchdog increments each cycle.
    - aes_out_valid_i=1: capture aes_out_i, rsp_err=0, go RESP.
    - Else if watchdog==TIMEOUT_CYC-1: rsp_data=0, rsp_err=1, go CLEAR.
    - If out-valid and timeout coincide, out-valid wins (normal response).
  - CLEAR: aes_clear_o=1 for CLR_CYC cycles, then go RESP.
  - RESP: rsp_valid_o=1; id/data/err held stable until rsp_ready_i. On accept, RR pointer = granted ID+1 mod NREQ, go IDLE.
- Grant latency: grant edge to aes_start_o is 2 cycles.
- Response latency: first rsp_valid_o cycle is 1 cycle after the out-valid edge.
- aes_out_valid_i outside WAIT is ignored. A second valid pulse during RESP does not overwrite the response.
- req_valid_i dropping before grant is legal; no grant results.
- Only one job is in flight at a time; no pipelining.
- Fairness: a continuously requesting requester waits at most NREQ-1 jobs.

Test Plan:
- Single job, requester 0:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff; model core returns 69c4e0d86a7b0430d8cdb78070b4c55a 10 cycles after start.
  - Required: rsp_id=0, rsp_err=0, matching data; aes_start_o high exactly 1 cycle, 2 cycles after grant.
- Round-robin: all 4 requesters held valid for 8 jobs.
  - Required: grant order 0,1,2,3,0,1,2,3.
  - Then only requesters 1 and 3 valid: order alternates 1,3.
- Timeout: model core never asserts out-valid.
  - Required: after 64 WAIT cycles, aes_clear_o high 4 cycles, then rsp_err=1, rsp_data=0.
  - Next job proceeds normally.
- Boundary, out-valid and timeout in the same cycle:
  - Stimulus: out-valid on WAIT cycle 64.
  - Required: normal response, rsp_err=0, aes_clear_o never asserted.
- Backpressure: rsp_ready_i low for 20 cycles with a spurious out-valid pulse during RESP.
  - Required: response fields stable throughout; no new grant until accept.
- Reset mid-WAIT:
  - Stimulus: rst_i asserted for 1 cycle in WAIT.
  - Required: next cycle state IDLE, all outputs 0, no response.
  - Pending requester 2 is then granted first only if RR pointer=0 and requesters 0/1 idle.

Source files
------------

// File: rtl/aes_job_sched.sv
// Round-robin scheduler sharing one AES core between NREQ requesters.
// Runs one job at a time. A watchdog aborts a stalled core with an error response and a core clear.
module aes_job_sched #(
  parameter int NREQ        = 4,
  parameter int IDW         = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int CLR_CYC     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*128-1:0]   req_key_i,
  input  logic [NREQ*128-1:0]   req_data_i,
  output logic [127:0]          aes_key_o,
  output logic [127:0]          aes_data_o,
  output logic                  aes_start_o,
  output logic                  aes_clear_o,
  input  logic                  aes_idle_i,
  input  logic                  aes_out_valid_i,
  input  logic [127:0]          aes_out_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [IDW-1:0]        rsp_id_o,
  output logic [127:0]          rsp_data_o,
  output logic                  rsp_err_o,
  output logic                  busy_o
);

  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  localparam int CW  = $clog2(CLR_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_CLEAR,
    S_RESP
  } state_t;

  state_t          state;
  logic [IDW-1:0]  rr;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  sel;
  logic [IDW-1:0]  idx;
  logic [IDW:0]    sum;
  logic            found;
  logic            grant;
  logic [WDW-1:0]  wd;
  logic [CW-1:0]   clr_cnt;
  logic [127:0]    key_q;
  logic [127:0]    data_q;
  logic [127:0]    rsp_data_q;
  logic            rsp_err_q;

  // First requesting slot at or after the RR pointer, wrapping past NREQ-1.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    sum   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Gated by reset so the accept never fires while the state is being forced.
  assign grant       = (state == S_IDLE) && !rst_i && aes_idle_i && found;
  assign req_ready_o = grant ? (NREQ'(1) << sel) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      rr         <= '0;
      id_q       <= '0;
      wd         <= '0;
      clr_cnt    <= '0;
      key_q      <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            key_q  <= req_key_i[sel*128 +: 128];
            data_q <= req_data_i[sel*128 +: 128];
            id_q   <= sel;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          state <= S_START;
        end
        S_START: begin
          wd    <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Out-valid is tested first so it wins over a coincident timeout.
          if (aes_out_valid_i) begin
            rsp_data_q <= aes_out_i;
            rsp_err_q  <= 1'b0;
            state      <= S_RESP;
          end else if (wd == WDW'(TIMEOUT_CYC - 1)) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
            clr_cnt    <= '0;
            state      <= S_CLEAR;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_CLEAR: begin
          if (clr_cnt == CW'(CLR_CYC - 1)) begin
            state <= S_RESP;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rr    <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign aes_key_o   = key_q;
  assign aes_data_o  = data_q;
  assign aes_start_o = (state == S_START);
  assign aes_clear_o = (state == S_CLEAR);
  assign rsp_valid_o = (state == S_RESP);
  assign rsp_id_o    = id_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = (state != S_IDLE);

endmodule

// File: tb/tb_aes_job_sched.sv
// Bench for aes_job_sched: a table of jobs, then random jobs against a round-robin reference model.
// The bench also plays the AES core and drives out-valid at a chosen WAIT cycle.
module tb_aes_job_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int TMO  = 64;
  localparam int CLR  = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*128-1:0]  req_key;
  logic [NREQ*128-1:0]  req_data;
  logic [127:0]         aes_key;
  logic [127:0]         aes_data;
  logic                 aes_start;
  logic                 aes_clear;
  logic                 aes_idle = 1'b0;
  logic                 aes_out_valid = 1'b0;
  logic [127:0]         aes_out = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [IDW-1:0]       rsp_id;
  logic [127:0]         rsp_data;
  logic                 rsp_err;
  logic                 busy;

  logic [127:0] key  [NREQ];
  logic [127:0] data [NREQ];

  int vectors     = 0;
  int miscompares = 0;
  int rr_m        = 0;

  typedef struct {
    logic [3:0] mask;
    int         vcyc;
    int         hold;
    int         exp_id;
    logic       exp_err;
  } vec_t;

  vec_t tbl [20];

  always #5 clk = ~clk;

  always_comb begin
    req_key  = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_key[i*128 +: 128]  = key[i];
      req_data[i*128 +: 128] = data[i];
    end
  end

  aes_job_sched #(
    .NREQ(NREQ),
    .IDW(IDW),
    .TIMEOUT_CYC(TMO),
    .CLR_CYC(CLR)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_key_i(req_key),
    .req_data_i(req_data),
    .aes_key_o(aes_key),
    .aes_data_o(aes_data),
    .aes_start_o(aes_start),
    .aes_clear_o(aes_clear),
    .aes_idle_i(aes_idle),
    .aes_out_valid_i(aes_out_valid),
    .aes_out_i(aes_out),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id),
    .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err),
    .busy_o(busy)
  );

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int pick(input logic [3:0] m, input int r);
    for (int k = 0; k < NREQ; k++) begin
      if (m[(r + k) % NREQ]) return (r + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic new_keys();
    for (int i = 0; i < NREQ; i++) begin
      key[i]  = rnd128();
      data[i] = rnd128();
    end
  endtask

  // One full job; entered and left at a negedge. vcyc = WAIT cycle carrying out-valid (outside 1..TMO means never).
  task automatic run_job(input logic [3:0] mask, input int vcyc, input int hold,
                         input int exp_id, input logic exp_err, input logic [127:0] ct);
    logic         found;
    logic         got;
    logic [127:0] exp_data;
    found = 1'b0;
    got   = 1'b0;
    exp_data = exp_err ? '0 : ct;
    req_valid = mask;
    aes_idle  = 1'b1;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (req_ready != '0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("grant", {124'b0, req_ready}, 128'(1) << exp_id);
    if (!found) begin
      req_valid = '0;
      return;
    end
    @(negedge clk);
    check("load_key", aes_key, key[exp_id]);
    check("load_data", aes_data, data[exp_id]);
    check("load_ctl", {req_ready, aes_start, aes_clear, rsp_valid, busy}, 8'b0000_0001);
    @(negedge clk);
    check("start_ctl", {req_ready, aes_start, aes_clear, rsp_valid, busy}, 8'b0000_1001);
    for (int c = 1; c <= TMO; c++) begin
      @(negedge clk);
      check("wait_ctl", {req_ready, aes_start, aes_clear, rsp_valid, busy}, 8'b0000_0001);
      if (c == vcyc) begin
        aes_out_valid = 1'b1;
        aes_out       = ct;
        got           = 1'b1;
        break;
      end
    end
    @(negedge clk);
    aes_out_valid = 1'b0;
    aes_out       = rnd128();
    if (!got) begin
      for (int k = 0; k < CLR; k++) begin
        if (k > 0) @(negedge clk);
        check("clear_ctl", {req_ready, aes_start, aes_clear, rsp_valid, busy}, 8'b0000_0101);
      end
      @(negedge clk);
    end
    check("rsp_ctl", {req_ready, aes_start, aes_clear, rsp_valid, busy}, 8'b0000_0011);
    check("rsp_id", rsp_id, exp_id);
    check("rsp_data", rsp_data, exp_data);
    check("rsp_err", rsp_err, exp_err);
    check("rsp_key_held", aes_key, key[exp_id]);
    for (int h = 0; h < hold; h++) begin
      aes_out_valid = (h == 1);
      aes_out       = ~ct;
      @(negedge clk);
      aes_out_valid = 1'b0;
      check("hold_ctl", {req_ready, aes_start, aes_clear, rsp_valid, busy}, 8'b0000_0011);
      check("hold_id", rsp_id, exp_id);
      check("hold_data", rsp_data, exp_data);
      check("hold_err", rsp_err, exp_err);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = '0;
    check("accept_ctl", {aes_start, aes_clear, rsp_valid, busy}, 4'b0000);
    rr_m = (exp_id + 1) % NREQ;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic         seen;
    logic [3:0]   m;
    int           v;
    logic [127:0] ct;

    tbl[0] = '{4'b0001, 10, 0, 0, 1'b0};
    tbl[1] = '{4'b1000, 1, 0, 3, 1'b0};
    for (int k = 0; k < 8; k++) tbl[2+k] = '{4'b1111, 3 + k, k % 2, k % 4, 1'b0};
    for (int k = 0; k < 4; k++) tbl[10+k] = '{4'b1010, 12, 0, (k % 2) ? 3 : 1, 1'b0};
    tbl[14] = '{4'b1111, 0, 1, 0, 1'b1};
    tbl[15] = '{4'b1111, 5, 0, 1, 1'b0};
    tbl[16] = '{4'b0100, TMO, 0, 2, 1'b0};
    tbl[17] = '{4'b1001, 7, 20, 3, 1'b0};
    tbl[18] = '{4'b0010, 2, 0, 1, 1'b0};
    tbl[19] = '{4'b0001, TMO + 1, 2, 0, 1'b1};

    new_keys();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_ctl", {req_ready, aes_start, aes_clear, rsp_valid, busy}, 8'b0);
    check("reset_key", aes_key, '0);
    check("reset_data", aes_data, '0);
    check("reset_rsp", {rsp_id, rsp_err, rsp_data}, '0);

    // Core not idle: requests must not be granted, and dropping them leaves no trace.
    req_valid = 4'b1111;
    repeat (4) begin
      @(negedge clk);
      check("busy_core_no_grant", {req_ready, aes_start, aes_clear, rsp_valid, busy}, 8'b0);
    end
    req_valid = '0;

    for (int i = 0; i < 20; i++) begin
      new_keys();
      ct = rnd128();
      if (i == 0) begin
        key[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        data[0] = 128'h00112233445566778899aabbccddeeff;
        ct      = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      end
      run_job(tbl[i].mask, tbl[i].vcyc, tbl[i].hold, tbl[i].exp_id, tbl[i].exp_err, ct);
    end

    for (int i = 0; i < 30; i++) begin
      new_keys();
      m = 4'($urandom_range(1, 15));
      v = $urandom_range(1, TMO + 6);
      run_job(m, v, $urandom_range(0, 3), pick(m, rr_m), v > TMO, rnd128());
    end

    // Reset in WAIT drops the job; the pointer returns to 0.
    new_keys();
    run_job(4'b0100, 6, 0, 2, 1'b0, rnd128());
    new_keys();
    req_valid = 4'b1000;
    #1;
    check("rst_pre_grant", req_ready, 4'b1000);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_ctl", {req_ready, aes_start, aes_clear, rsp_valid, busy}, 8'b0);
    check("rst_mid_key", aes_key, '0);
    check("rst_mid_data", aes_data, '0);
    check("rst_mid_rsp", {rsp_id, rsp_err, rsp_data}, '0);
    seen = 1'b0;
    for (int i = 0; i < TMO + 10; i++) begin
      aes_out_valid = (i == 3);
      aes_out       = rnd128();
      @(negedge clk);
      aes_out_valid = 1'b0;
      seen = seen | rsp_valid | aes_clear | busy;
    end
    check("rst_no_response", seen, 1'b0);
    rr_m = 0;
    new_keys();
    run_job(4'b0110, 9, 1, 1, 1'b0, rnd128());
    new_keys();
    run_job(4'b0100, 4, 0, 2, 1'b0, rnd128());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
